lp_accum_pe: RTL and testbench

- Parametrised successor to the linear processing array element: one output-accumulating fixed-point MAC PE with AXI-Stream interfaces.
- Joins an "up" stream (operand 1, weights) and a "left" stream (operand 0, data) beat by beat and accumulates their products over a tlast-delimited vector.
- Emits one rounded, optionally saturated result per vector on the "down" stream.
- Adds behaviour the array does not have: configurable vector-length enforcement, rounding and saturation modes, and per-event error pulses.

---
 rtl/lp_accum_pe.sv | 183 ++++++++++++++++++
 tb/tb_lp_accum_pe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lp_accum_pe.sv
// Output-accumulating fixed-point MAC processing element.
// Joins up (weights) and left (data) AXI-Stream beats, accumulates products per vector, emits one rounded result.
module lp_accum_pe #(
   parameter int DATA_WIDTH_OP0       = 16,
   parameter int FRACTIONAL_BITS_OP0  = 12,
   parameter int IS_UNSIGNED_OP0      = 0,
   parameter int DATA_WIDTH_OP1       = 16,
   parameter int FRACTIONAL_BITS_OP1  = 12,
   parameter int IS_UNSIGNED_OP1      = 0,
   parameter int DATA_WIDTH_RSLT      = 16,
   parameter int FRACTIONAL_BITS_RSLT = 12,
   parameter int ACC_GUARD_BITS       = 8,
   parameter int ROUND                = 1,
   parameter int SATURATE             = 1,
   parameter int VEC_LEN              = 0,
   parameter int USER_WIDTH           = 8,
   parameter int OUTPUT_DEST          = 0,
   parameter int DEST_WIDTH           = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH_OP1-1:0]  s_axis_up_tdata,
   input  logic                       s_axis_up_tvalid,
   output logic                       s_axis_up_tready,
   input  logic                       s_axis_up_tlast,
   input  logic [USER_WIDTH-1:0]      s_axis_up_tuser,
   input  logic [DATA_WIDTH_OP0-1:0]  s_axis_left_tdata,
   input  logic                       s_axis_left_tvalid,
   output logic                       s_axis_left_tready,
   input  logic                       s_axis_left_tlast,
   output logic [DATA_WIDTH_RSLT-1:0] m_axis_down_tdata,
   output logic                       m_axis_down_tvalid,
   input  logic                       m_axis_down_tready,
   output logic                       m_axis_down_tlast,
   output logic [USER_WIDTH-1:0]      m_axis_down_tuser,
   output logic [DEST_WIDTH-1:0]      m_axis_down_tdest,
   output logic                       err_unaligned_data,
   output logic                       err_length,
   output logic                       err_saturation
);

   localparam int PROD_W = DATA_WIDTH_OP0 + DATA_WIDTH_OP1;
   localparam int XW     = PROD_W + 2;
   localparam int ACC_W  = PROD_W + ACC_GUARD_BITS;
   localparam int EW     = ACC_W + 1;
   localparam int RW     = DATA_WIDTH_RSLT;
   localparam int SH     = FRACTIONAL_BITS_OP0 + FRACTIONAL_BITS_OP1 - FRACTIONAL_BITS_RSLT;
   localparam int RB_SH  = (SH > 0) ? SH - 1 : 0;
   localparam int VL     = (VEC_LEN > 0) ? VEC_LEN : 1;
   localparam int CNT_W  = (VL > 1) ? $clog2(VL) : 1;
   localparam bit RSLT_SIGNED = !((IS_UNSIGNED_OP0 != 0) && (IS_UNSIGNED_OP1 != 0));

   localparam logic signed [EW-1:0] ONE_E    = {{(EW-1){1'b0}}, 1'b1};
   localparam logic signed [EW-1:0] MAX_V    = RSLT_SIGNED ? (ONE_E <<< (RW - 1)) - ONE_E
                                                            : (ONE_E <<< RW) - ONE_E;
   localparam logic signed [EW-1:0] MIN_V    = RSLT_SIGNED ? -(ONE_E <<< (RW - 1)) : {EW{1'b0}};
   localparam logic signed [EW-1:0] RND_BIAS = ((ROUND != 0) && (SH > 0)) ? (ONE_E <<< RB_SH)
                                                                            : {EW{1'b0}};

   // One extra MSB keeps the rounding bias from overflowing before the arithmetic shift.
   function automatic logic signed [EW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
      logic signed [EW-1:0] ext;
      ext = EW'(a) + RND_BIAS;
      return ext >>> SH;
   endfunction

   // Returns {clamped_flag, result}.
   function automatic logic [RW:0] saturate(input logic signed [EW-1:0] v);
      logic [RW:0] r;
      if (SATURATE == 0) begin
         r = {1'b0, v[RW-1:0]};
      end else if (v > MAX_V) begin
         r = {1'b1, MAX_V[RW-1:0]};
      end else if (v < MIN_V) begin
         r = {1'b1, MIN_V[RW-1:0]};
      end else begin
         r = {1'b0, v[RW-1:0]};
      end
      return r;
   endfunction

   logic                      can_accept_s;
   logic                      fire_s;
   logic                      any_last_s;
   logic                      last_cnt_s;
   logic                      unaligned_s;
   logic                      eov_s;
   logic                      len_err_s;
   logic signed [DATA_WIDTH_OP0:0] op0_x_s;
   logic signed [DATA_WIDTH_OP1:0] op1_x_s;
   logic signed [XW-1:0]      prod_x_s;
   logic signed [ACC_W-1:0]   prod_acc_s;
   logic signed [ACC_W-1:0]   acc_sum_s;
   logic [RW:0]               sat_pack_s;

   logic signed [ACC_W-1:0]   acc_r;
   logic [CNT_W-1:0]          count_r;
   logic                      first_r;
   logic                      down_valid_r;
   logic [RW-1:0]             down_data_r;
   logic [USER_WIDTH-1:0]     down_user_r;
   logic                      err_unaligned_r;
   logic                      err_length_r;
   logic                      err_saturation_r;

   // Join handshake and end-of-vector decision.
   always_comb begin
      can_accept_s = !down_valid_r || m_axis_down_tready;
      fire_s       = s_axis_up_tvalid && s_axis_left_tvalid && can_accept_s;
      any_last_s   = s_axis_up_tlast || s_axis_left_tlast;
      unaligned_s  = s_axis_up_tlast != s_axis_left_tlast;
      last_cnt_s   = (count_r == CNT_W'(VL - 1));
      if (VEC_LEN == 0) begin
         eov_s     = any_last_s;
         len_err_s = 1'b0;
      end else begin
         eov_s     = last_cnt_s;
         len_err_s = any_last_s != last_cnt_s;
      end
   end

   // Operand extension, product, running sum and result formatting.
   always_comb begin
      if (IS_UNSIGNED_OP0 != 0) begin
         op0_x_s = {1'b0, s_axis_left_tdata};
      end else begin
         op0_x_s = {s_axis_left_tdata[DATA_WIDTH_OP0-1], s_axis_left_tdata};
      end
      if (IS_UNSIGNED_OP1 != 0) begin
         op1_x_s = {1'b0, s_axis_up_tdata};
      end else begin
         op1_x_s = {s_axis_up_tdata[DATA_WIDTH_OP1-1], s_axis_up_tdata};
      end
      prod_x_s   = op0_x_s * op1_x_s;
      prod_acc_s = ACC_W'(prod_x_s);
      acc_sum_s  = (first_r ? {ACC_W{1'b0}} : acc_r) + prod_acc_s;
      sat_pack_s = saturate(round_shift(acc_sum_s));
   end

   // Accumulator, beat counter, output register and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r            <= {ACC_W{1'b0}};
         count_r          <= {CNT_W{1'b0}};
         first_r          <= 1'b1;
         down_valid_r     <= 1'b0;
         down_data_r      <= {RW{1'b0}};
         down_user_r      <= {USER_WIDTH{1'b0}};
         err_unaligned_r  <= 1'b0;
         err_length_r     <= 1'b0;
         err_saturation_r <= 1'b0;
      end else begin
         err_unaligned_r  <= fire_s && unaligned_s;
         err_length_r     <= fire_s && len_err_s;
         err_saturation_r <= fire_s && eov_s && sat_pack_s[RW];
         if (fire_s) begin
            acc_r   <= acc_sum_s;
            first_r <= eov_s;
            count_r <= eov_s ? {CNT_W{1'b0}} : count_r + CNT_W'(1);
         end
         // A new result may load in the same cycle the previous one is taken.
         if (fire_s && eov_s) begin
            down_valid_r <= 1'b1;
            down_data_r  <= sat_pack_s[RW-1:0];
            down_user_r  <= s_axis_up_tuser;
         end else if (m_axis_down_tready) begin
            down_valid_r <= 1'b0;
         end
      end
   end

   assign s_axis_up_tready   = s_axis_left_tvalid && can_accept_s;
   assign s_axis_left_tready = s_axis_up_tvalid && can_accept_s;
   assign m_axis_down_tvalid = down_valid_r;
   assign m_axis_down_tlast  = down_valid_r;
   assign m_axis_down_tdata  = down_data_r;
   assign m_axis_down_tuser  = down_user_r;
   assign m_axis_down_tdest  = DEST_WIDTH'(OUTPUT_DEST);
   assign err_unaligned_data = err_unaligned_r;
   assign err_length         = err_length_r;
   assign err_saturation     = err_saturation_r;

endmodule

// File: tb/tb_lp_accum_pe.sv
// Directed bench for lp_accum_pe: three instances (default, no-round/wrap, VEC_LEN=3) driven independently.
module tb_lp_accum_pe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] up_data[3];
   logic [15:0] left_data[3];
   logic        up_valid[3];
   logic        left_valid[3];
   logic        up_last[3];
   logic        left_last[3];
   logic [7:0]  up_user[3];
   logic        down_ready[3];
   logic        up_ready[3];
   logic        left_ready[3];
   logic [15:0] down_data[3];
   logic        down_valid[3];
   logic        down_last[3];
   logic [7:0]  down_user[3];
   logic [7:0]  down_dest[3];
   logic        err_u[3];
   logic        err_l[3];
   logic        err_s[3];

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      lp_accum_pe #(
         .ROUND      ((g == 1) ? 0 : 1),
         .SATURATE   ((g == 1) ? 0 : 1),
         .VEC_LEN    ((g == 2) ? 3 : 0),
         .OUTPUT_DEST((g == 2) ? 60 : 0)
      ) u_dut (
         .clk               (clk),
         .rst               (rst),
         .s_axis_up_tdata   (up_data[g]),
         .s_axis_up_tvalid  (up_valid[g]),
         .s_axis_up_tready  (up_ready[g]),
         .s_axis_up_tlast   (up_last[g]),
         .s_axis_up_tuser   (up_user[g]),
         .s_axis_left_tdata (left_data[g]),
         .s_axis_left_tvalid(left_valid[g]),
         .s_axis_left_tready(left_ready[g]),
         .s_axis_left_tlast (left_last[g]),
         .m_axis_down_tdata (down_data[g]),
         .m_axis_down_tvalid(down_valid[g]),
         .m_axis_down_tready(down_ready[g]),
         .m_axis_down_tlast (down_last[g]),
         .m_axis_down_tuser (down_user[g]),
         .m_axis_down_tdest (down_dest[g]),
         .err_unaligned_data(err_u[g]),
         .err_length        (err_l[g]),
         .err_saturation    (err_s[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one joined beat and returns #1 after the edge that consumes it.
   task automatic beat(input int k, input logic [15:0] u, input logic [15:0] l,
                       input logic ul, input logic ll, input logic [7:0] usr);
      logic ok;
      @(negedge clk);
      up_data[k] = u; left_data[k] = l; up_last[k] = ul; left_last[k] = ll;
      up_user[k] = usr; up_valid[k] = 1'b1; left_valid[k] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (up_ready[k] && left_ready[k]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk($sformatf("beat_fire%0d", k), 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      up_valid[k] = 1'b0; left_valid[k] = 1'b0; up_last[k] = 1'b0; left_last[k] = 1'b0;
   endtask

   task automatic chk_res(input string tag, input int k, input logic [15:0] data, input logic [7:0] usr);
      chk({tag, "_valid"}, 32'(down_valid[k]), 32'd1);
      chk({tag, "_last"},  32'(down_last[k]),  32'd1);
      chk({tag, "_data"},  32'(down_data[k]),  32'(data));
      chk({tag, "_user"},  32'(down_user[k]),  32'(usr));
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         up_data[k] = 16'h0000; left_data[k] = 16'h0000; up_valid[k] = 1'b0; left_valid[k] = 1'b0;
         up_last[k] = 1'b0; left_last[k] = 1'b0; up_user[k] = 8'h00; down_ready[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_valid%0d", k), 32'(down_valid[k]), 32'd0);
         chk($sformatf("rst_data%0d", k),  32'(down_data[k]),  32'd0);
         chk($sformatf("rst_errs%0d", k),  32'({err_u[k], err_l[k], err_s[k]}), 32'd0);
      end
      chk("rst_dest0", 32'(down_dest[0]), 32'h00);
      chk("rst_dest2", 32'(down_dest[2]), 32'h3C);
      @(negedge clk);
      rst = 1'b0;

      // Signed 4-beat vector: 2 + 1 - 1 + 0.5 = 2.5
      beat(0, 16'h1000, 16'h2000, 1'b0, 1'b0, 8'h11);
      beat(0, 16'h1000, 16'h1000, 1'b0, 1'b0, 8'h12);
      beat(0, 16'h1000, 16'hF000, 1'b0, 1'b0, 8'h13);
      chk("vec_early_valid", 32'(down_valid[0]), 32'd0);
      beat(0, 16'h1000, 16'h0800, 1'b1, 1'b1, 8'hA5);
      chk_res("vec", 0, 16'h2800, 8'hA5);
      chk("vec_errs", 32'({err_u[0], err_l[0], err_s[0]}), 32'd0);
      @(posedge clk);
      #1;
      chk("vec_pulse_once", 32'(down_valid[0]), 32'd0);

      // Saturation vs wrap
      for (int i = 0; i < 3; i++) beat(0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 8'h00);
      beat(0, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 8'h5A);
      chk_res("sat", 0, 16'h7FFF, 8'h5A);
      chk("sat_err", 32'(err_s[0]), 32'd1);
      @(posedge clk);
      #1;
      chk("sat_err_clear", 32'(err_s[0]), 32'd0);
      for (int i = 0; i < 3; i++) beat(1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 8'h00);
      beat(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 8'h5B);
      chk_res("wrap", 1, 16'hFFC0, 8'h5B);
      chk("wrap_err", 32'(err_s[1]), 32'd0);

      // Rounding half up vs truncation, positive and negative half
      beat(0, 16'h0001, 16'h0800, 1'b1, 1'b1, 8'h01);
      chk("rnd_pos", 32'(down_data[0]), 32'h0001);
      beat(1, 16'h0001, 16'h0800, 1'b1, 1'b1, 8'h01);
      chk("trunc_pos", 32'(down_data[1]), 32'h0000);
      beat(0, 16'hFFFF, 16'h0800, 1'b1, 1'b1, 8'h02);
      chk("rnd_neg", 32'(down_data[0]), 32'h0000);
      beat(1, 16'hFFFF, 16'h0800, 1'b1, 1'b1, 8'h02);
      chk("trunc_neg", 32'(down_data[1]), 32'hFFFF);

      // Backpressure: pending result blocks both inputs and holds stable
      down_ready[0] = 1'b0;
      beat(0, 16'h1000, 16'h1000, 1'b1, 1'b1, 8'h21);
      @(negedge clk);
      up_data[0] = 16'h1000; left_data[0] = 16'h3000; up_last[0] = 1'b1; left_last[0] = 1'b1;
      up_user[0] = 8'h22; up_valid[0] = 1'b1; left_valid[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_up_ready",   32'(up_ready[0]),   32'd0);
         chk("bp_left_ready", 32'(left_ready[0]), 32'd0);
         chk_res("bp_hold", 0, 16'h1000, 8'h21);
         @(negedge clk);
      end
      down_ready[0] = 1'b1;
      #1;
      chk("bp_release_ready", 32'({up_ready[0], left_ready[0]}), 32'd3);
      @(posedge clk);
      #1;
      up_valid[0] = 1'b0; left_valid[0] = 1'b0; up_last[0] = 1'b0; left_last[0] = 1'b0;
      chk_res("bp_next", 0, 16'h3000, 8'h22);

      // Misaligned tlast in tlast-delimited mode
      beat(0, 16'h1000, 16'h1000, 1'b0, 1'b0, 8'h30);
      beat(0, 16'h1000, 16'h2000, 1'b1, 1'b0, 8'h31);
      chk_res("mis_a", 0, 16'h3000, 8'h31);
      chk("mis_a_err", 32'(err_u[0]), 32'd1);
      beat(0, 16'h1000, 16'h0800, 1'b0, 1'b1, 8'h32);
      chk_res("mis_b", 0, 16'h0800, 8'h32);
      chk("mis_b_err", 32'(err_u[0]), 32'd1);
      @(posedge clk);
      #1;
      chk("mis_err_clear", 32'(err_u[0]), 32'd0);

      // Fixed length 3: early tlast and missing tlast both flag, vector still spans 3 beats
      beat(2, 16'h1000, 16'h1000, 1'b0, 1'b0, 8'h40);
      beat(2, 16'h1000, 16'h1000, 1'b1, 1'b1, 8'h40);
      chk("len_early_err",   32'(err_l[2]),      32'd1);
      chk("len_early_valid", 32'(down_valid[2]), 32'd0);
      beat(2, 16'h1000, 16'h1000, 1'b0, 1'b0, 8'h41);
      chk_res("len_a", 2, 16'h3000, 8'h41);
      chk("len_a_err",  32'(err_l[2]),     32'd1);
      chk("len_a_dest", 32'(down_dest[2]), 32'h3C);
      beat(2, 16'h1000, 16'h1000, 1'b0, 1'b0, 8'h42);
      beat(2, 16'h1000, 16'h1000, 1'b0, 1'b0, 8'h42);
      beat(2, 16'h1000, 16'h2000, 1'b1, 1'b1, 8'h42);
      chk_res("len_b", 2, 16'h4000, 8'h42);
      chk("len_b_err", 32'(err_l[2]), 32'd0);

      // Reset discards a pending result and a partial sum
      down_ready[0] = 1'b0;
      beat(0, 16'h1000, 16'h4000, 1'b0, 1'b0, 8'h50);
      beat(0, 16'h1000, 16'h1000, 1'b1, 1'b1, 8'h50);
      chk_res("pend", 0, 16'h5000, 8'h50);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_pend_valid", 32'(down_valid[0]), 32'd0);
      chk("rst_pend_data",  32'(down_data[0]),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      down_ready[0] = 1'b1;
      beat(0, 16'h1000, 16'h4000, 1'b0, 1'b0, 8'h51);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_valid", 32'(down_valid[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      beat(0, 16'h1000, 16'h1000, 1'b1, 1'b1, 8'h52);
      chk_res("rst_fresh", 0, 16'h1000, 8'h52);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
